data_island_scheduler: RTL and testbench
========================================

Name: data_island_scheduler

Overview:
- Sequences HDMI data island periods inside the blanking interval.
- Shares the packet slots of each island between NUM_REQ packet sources (infoframes, audio sample, audio clock regeneration, ...) using round-robin plus an urgent override.
- Drives the packet timing the packet assembler consumes: packet_enable, packet_pixel_counter, and one-hot grant selecting the source.
- Sits between the video timing generator and the packet assembler / TMDS channel mux.

Parameters:
- NUM_REQ, 4, number of packet requesters (1..8).
- MAX_PACKETS, 18, maximum packets per data island.
- MIN_CONTROL, 12, minimum control-period pixels required after the trailing guard band.
- WINDOW_W, 12, width of window_remaining.

Ports:
- clk_pixel  in  1  pixel clock; single clock domain.
- reset  in  1  asynchronous, active-high reset.
- island_window  in  1  high while the current pixel is in blanking where islands are permitted.
- window_remaining  in  WINDOW_W  pixels left in the window, including the current cycle; valid when island_window=1.
- req  in  NUM_REQ  level request per source; held until ack.
- urgent  in  NUM_REQ  per-source urgent flag; qualified by req.
- grant  out  NUM_REQ  one-hot source of the current packet; all-zero outside PACKET.
- ack  out  NUM_REQ  one-cycle pulse to the granted source on the first pixel of its packet.
- preamble  out  1  high during the 8 preamble pixels.
- guard  out  1  high during leading and trailing guard-band pixels.
- data_island_period  out  1  high during PACKET pixels.
- packet_enable  out  1  pulse on pixel 0 of every packet.
- packet_pixel_counter  out  5  pixel index 0..31 within the current packet.

Behaviour:
- Reset (async assert, sync release): state=IDLE; all outputs 0; rr_ptr=0; pkt_count=0.
- States: IDLE, PREAMBLE(8), LEAD_GUARD(2), PACKET(32 per packet), TRAIL_GUARD(2), COOLDOWN(MIN_CONTROL). Counts are cycles in each state.
- IDLE -> PREAMBLE when island_window=1, |req=1, and window_remaining >= 44+MIN_CONTROL.
  - Transition takes effect the next cycle; preamble is asserted from that cycle.
- PREAMBLE -> LEAD_GUARD after 8 cycles.
  - If island_window falls during PREAMBLE: abort to IDLE, no grant issued.
- LEAD_GUARD -> PACKET after 2 cycles.
  - Arbitration is evaluated on the last LEAD_GUARD cycle and registered into grant for the first PACKET cycle.
  - If no req is present at that point, a NULL slot is used: grant=0, packet still emitted.
- PACKET:
  - packet_pixel_counter counts 0..31, then wraps to 0.
  - packet_enable=1 and ack=grant at counter 0.
  - grant is held constant for all 32 cycles.
- At counter 31, after incrementing pkt_count, one of:
  - Another PACKET, if |req, pkt_count < MAX_PACKETS, island_window=1, and window_remaining >= 35+MIN_CONTROL. Arbitration result is registered for the next cycle, giving back-to-back packets with no gap.
  - Otherwise TRAIL_GUARD.
  - island_window dropping mid-packet does not truncate the packet.
- TRAIL_GUARD(2) -> COOLDOWN(MIN_CONTROL) -> IDLE.
  - pkt_count clears on entry to IDLE.
  - A new island cannot start before COOLDOWN completes.
- Arbitration:
  - If any req&urgent is set, pick the lowest index among the urgent requesters.
  - Otherwise round-robin over req starting at rr_ptr.
  - rr_ptr <= granted index + 1 (mod NUM_REQ), updated only on non-urgent grants.
- A source's req may drop only after its ack.
  - A req deasserted before arbitration is simply not considered.
- Outputs are registered; preamble, guard, and data_island_period are mutually exclusive.

Test Plan:
- Reset mid-PACKET, at counter=17 -> same cycle: grant=0, data_island_period=0, packet_pixel_counter=0; next island restarts from PREAMBLE with rr_ptr=0.
- req=4'b0001, window opens with window_remaining=200 -> 8 preamble, 2 guard, 32 PACKET (grant=0001, ack pulse at counter 0), 2 guard, 12 cooldown, IDLE. Total 56 cycles.
- req=4'b1111 held, ack-driven drop, window_remaining=1000 -> grants 0001, 0010, 0100, 1000 back-to-back within one island; each packet_enable is 32 cycles apart.
- req=4'b0110, urgent=4'b0100 -> first grant 0100, then 0010; rr_ptr unchanged by the urgent grant.
- req=all set continuously, window_remaining=2000 -> island ends after exactly 18 packets; TRAIL_GUARD entered at pkt_count=18.
- Window-boundary edge cases:
  - window_remaining=55 at window start -> no island.
  - window_remaining=56 -> one island, single packet.
  - Mid-island with window_remaining=46 at counter 31 -> TRAIL_GUARD, not another packet.

Source files
------------

// File: rtl/data_island_scheduler.sv
// HDMI data island sequencer: frames islands inside blanking and shares their
// packet slots between NUM_REQ sources (urgent-first, then round-robin).
module data_island_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int MAX_PACKETS = 18,
  parameter int MIN_CONTROL = 12,
  parameter int WINDOW_W    = 12
) (
  input  logic                clk_pixel,
  input  logic                reset,
  input  logic                island_window,
  input  logic [WINDOW_W-1:0] window_remaining,
  input  logic [NUM_REQ-1:0]  req,
  input  logic [NUM_REQ-1:0]  urgent,
  output logic [NUM_REQ-1:0]  grant,
  output logic [NUM_REQ-1:0]  ack,
  output logic                preamble,
  output logic                guard,
  output logic                data_island_period,
  output logic                packet_enable,
  output logic [4:0]          packet_pixel_counter
);

  localparam int CW = (MIN_CONTROL > 32) ? $clog2(MIN_CONTROL) : 5;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int KW = $clog2(MAX_PACKETS + 1);

  // 44 = preamble + lead guard + one packet + trail guard
  localparam logic [WINDOW_W-1:0] START_MIN = WINDOW_W'(44 + MIN_CONTROL);
  localparam logic [WINDOW_W-1:0] NEXT_MIN  = WINDOW_W'(35 + MIN_CONTROL);
  localparam logic [CW-1:0] PRE_LAST  = CW'(7);
  localparam logic [CW-1:0] GRD_LAST  = CW'(1);
  localparam logic [CW-1:0] PKT_LAST  = CW'(31);
  localparam logic [CW-1:0] COOL_LAST = CW'(MIN_CONTROL - 1);
  localparam logic [KW-1:0] MAX_PK    = KW'(MAX_PACKETS);
  localparam logic [PW-1:0] LAST_IDX  = PW'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_PREAMBLE, S_LEAD_GUARD, S_PACKET, S_TRAIL_GUARD, S_COOLDOWN
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt, cnt_nx;
  logic [KW-1:0]      pkt_count, pkt_count_nx;
  logic [NUM_REQ-1:0] grant_nx;
  logic [PW-1:0]      rr_ptr, rr_nx;

  logic [NUM_REQ-1:0] urg_req, arb_gnt;
  logic               arb_urgent;
  logic [PW-1:0]      arb_idx, rr_idx, rr_inc;

  // Descending loops so the lowest index / smallest rr offset wins last.
  always_comb begin
    urg_req    = req & urgent;
    arb_urgent = |urg_req;
    arb_gnt    = '0;
    arb_idx    = '0;
    rr_idx     = '0;
    if (arb_urgent) begin
      for (int i = NUM_REQ - 1; i >= 0; i--) begin
        if (urg_req[i]) begin
          arb_gnt    = '0;
          arb_gnt[i] = 1'b1;
          arb_idx    = PW'(i);
        end
      end
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        rr_idx = PW'((int'(rr_ptr) + k) % NUM_REQ);
        if (req[rr_idx]) begin
          arb_gnt         = '0;
          arb_gnt[rr_idx] = 1'b1;
          arb_idx         = rr_idx;
        end
      end
    end
    rr_inc = (arb_idx == LAST_IDX) ? '0 : arb_idx + 1'b1;
  end

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + 1'b1;
    pkt_count_nx = pkt_count;
    grant_nx     = grant;
    rr_nx        = rr_ptr;
    case (state)
      S_IDLE: begin
        cnt_nx       = '0;
        pkt_count_nx = '0;
        if (island_window && |req && window_remaining >= START_MIN)
          state_nx = S_PREAMBLE;
      end
      S_PREAMBLE: begin
        if (!island_window) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
        end else if (cnt == PRE_LAST) begin
          state_nx = S_LEAD_GUARD;
          cnt_nx   = '0;
        end
      end
      S_LEAD_GUARD: begin
        if (cnt == GRD_LAST) begin
          state_nx = S_PACKET;
          cnt_nx   = '0;
          grant_nx = arb_gnt;  // all-zero here means a null packet
          if (!arb_urgent && |req) rr_nx = rr_inc;
        end
      end
      S_PACKET: begin
        if (cnt == PKT_LAST) begin
          cnt_nx       = '0;
          pkt_count_nx = pkt_count + 1'b1;
          if (|req && pkt_count_nx < MAX_PK && island_window &&
              window_remaining >= NEXT_MIN) begin
            grant_nx = arb_gnt;
            if (!arb_urgent) rr_nx = rr_inc;
          end else begin
            state_nx = S_TRAIL_GUARD;
            grant_nx = '0;
          end
        end
      end
      S_TRAIL_GUARD: begin
        if (cnt == GRD_LAST) begin
          state_nx = S_COOLDOWN;
          cnt_nx   = '0;
        end
      end
      S_COOLDOWN: begin
        if (cnt == COOL_LAST) begin
          state_nx     = S_IDLE;
          cnt_nx       = '0;
          pkt_count_nx = '0;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
        grant_nx = '0;
      end
    endcase
  end

  // Outputs are flopped from the next-state decode so they line up with state.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state                <= S_IDLE;
      cnt                  <= '0;
      pkt_count            <= '0;
      rr_ptr               <= '0;
      grant                <= '0;
      ack                  <= '0;
      preamble             <= 1'b0;
      guard                <= 1'b0;
      data_island_period   <= 1'b0;
      packet_enable        <= 1'b0;
      packet_pixel_counter <= '0;
    end else begin
      state                <= state_nx;
      cnt                  <= cnt_nx;
      pkt_count            <= pkt_count_nx;
      rr_ptr               <= rr_nx;
      grant                <= grant_nx;
      ack                  <= (state_nx == S_PACKET && cnt_nx == '0) ? grant_nx : '0;
      preamble             <= (state_nx == S_PREAMBLE);
      guard                <= (state_nx == S_LEAD_GUARD) || (state_nx == S_TRAIL_GUARD);
      data_island_period   <= (state_nx == S_PACKET);
      packet_enable        <= (state_nx == S_PACKET) && (cnt_nx == '0);
      packet_pixel_counter <= (state_nx == S_PACKET) ? cnt_nx[4:0] : 5'd0;
    end
  end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Randomized bench for data_island_scheduler against a timeline model of an island
// (position since preamble start, packets counted, arbitration by plain rules).
module tb_data_island_scheduler;
  localparam int N = 4, MAXP = 18, MC = 12, WW = 12;

  logic          clk_pixel = 1'b0;
  logic          reset;
  logic          island_window;
  logic [WW-1:0] window_remaining;
  logic [N-1:0]  req, urgent, grant, ack;
  logic          preamble, guard, data_island_period, packet_enable;
  logic [4:0]    packet_pixel_counter;

  always #5 clk_pixel = ~clk_pixel;

  data_island_scheduler #(.NUM_REQ(N), .MAX_PACKETS(MAXP), .MIN_CONTROL(MC), .WINDOW_W(WW)) dut (
    .clk_pixel(clk_pixel), .reset(reset), .island_window(island_window),
    .window_remaining(window_remaining), .req(req), .urgent(urgent),
    .grant(grant), .ack(ack), .preamble(preamble), .guard(guard),
    .data_island_period(data_island_period), .packet_enable(packet_enable),
    .packet_pixel_counter(packet_pixel_counter)
  );

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  // model: island timeline
  bit           m_act;
  int           m_pos, m_tail, m_npk, m_rr;
  logic [N-1:0] m_grant;
  bit           e_pre, e_grd, e_dip, e_pe;
  int           e_ppc;
  logic [N-1:0] e_gnt, e_ack;

  // stimulus state
  logic [N-1:0] pend, s_ufix;
  int           win_left, gap_left, s_wlen, s_gap, s_preq, s_purg, s_pdrop;
  bit           s_hold, rst17;
  int           cyc, n_pre, n_busy;
  logic [N-1:0] gq[$];
  int           tq[$];

  function automatic logic [N-1:0] arb(input logic [N-1:0] r, input logic [N-1:0] u);
    for (int i = 0; i < N; i++)
      if (r[i] && u[i]) return N'(1) << i;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (m_rr + k) % N;
      if (r[j]) begin
        m_rr = (j + 1) % N;
        return N'(1) << j;
      end
    end
    return '0;
  endfunction

  task automatic model_out();
    e_pre = m_act && m_pos < 8;
    e_dip = m_act && m_pos >= 10 && (m_tail < 0 || m_pos < m_tail);
    e_grd = m_act && ((m_pos >= 8 && m_pos < 10) ||
                      (m_tail >= 0 && m_pos >= m_tail && m_pos < m_tail + 2));
    e_ppc = e_dip ? (m_pos - 10) % 32 : 0;
    e_pe  = e_dip && e_ppc == 0;
    e_gnt = e_dip ? m_grant : '0;
    e_ack = e_pe ? m_grant : '0;
  endtask

  task automatic model_step();
    if (!m_act) begin
      if (island_window && |req && window_remaining >= 44 + MC) begin
        m_act = 1; m_pos = 0; m_tail = -1; m_npk = 0;
      end
    end else if (m_pos < 8 && !island_window) begin
      m_act = 0;
    end else if (m_tail >= 0 && m_pos == m_tail + 1 + MC) begin
      m_act = 0;
    end else begin
      if (m_pos == 9) m_grant = arb(req, urgent);
      else if (e_dip && e_ppc == 31) begin
        m_npk++;
        if (|req && m_npk < MAXP && island_window && window_remaining >= 35 + MC)
          m_grant = arb(req, urgent);
        else
          m_tail = m_pos + 1;
      end
      m_pos++;
    end
  endtask

  task automatic model_reset();
    m_act = 0; m_rr = 0; m_grant = '0; m_pos = 0; m_tail = -1; m_npk = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_grant"}, 32'(grant), 0);
    chk({tag, "_ack"}, 32'(ack), 0);
    chk({tag, "_pre"}, 32'(preamble), 0);
    chk({tag, "_guard"}, 32'(guard), 0);
    chk({tag, "_dip"}, 32'(data_island_period), 0);
    chk({tag, "_pe"}, 32'(packet_enable), 0);
    chk({tag, "_ppc"}, 32'(packet_pixel_counter), 0);
  endtask

  task automatic hard_reset();
    @(negedge clk_pixel);
    reset = 1; island_window = 0; req = '0; urgent = '0; window_remaining = '0;
    #1 chk_idle("rst");
    #1 reset = 0;
    model_reset();
  endtask

  task automatic tick();
    @(negedge clk_pixel);
    cyc++;
    model_out();
    chk("preamble", 32'(preamble), 32'(e_pre));
    chk("guard", 32'(guard), 32'(e_grd));
    chk("dip", 32'(data_island_period), 32'(e_dip));
    chk("pkt_en", 32'(packet_enable), 32'(e_pe));
    chk("pix_cnt", 32'(packet_pixel_counter), 32'(e_ppc));
    chk("grant", 32'(grant), 32'(e_gnt));
    chk("ack", 32'(ack), 32'(e_ack));
    if (preamble) n_pre++;
    if (preamble || guard || data_island_period) n_busy++;
    if (packet_enable) begin gq.push_back(grant); tq.push_back(cyc); end
    if (rst17 && e_dip && e_ppc == 17) begin
      rst17 = 0;
      reset = 1;
      #1 chk_idle("rst_mid");
      #1 reset = 0;
      model_reset();
      model_out();
    end
    if (win_left == 0 && gap_left == 0) begin
      win_left = (s_wlen > 0) ? s_wlen : int'($urandom_range(400, 30));
      gap_left = s_gap;
    end
    if (win_left > 0) begin
      island_window    = ($urandom_range(99) >= s_pdrop);
      window_remaining = WW'(win_left);
      win_left--;
    end else begin
      island_window    = 0;
      window_remaining = WW'($urandom);
      gap_left--;
    end
    for (int i = 0; i < N; i++) begin
      if (e_ack[i] && !s_hold) pend[i] = 0;
      else if (!pend[i] && $urandom_range(99) < s_preq) pend[i] = 1;
      urgent[i] = s_ufix[i] | ($urandom_range(99) < s_purg);
    end
    req = pend;
    model_step();
  endtask

  task automatic scen(input logic [N-1:0] r0, input logic [N-1:0] uf, input int wlen,
                      input int preq, input int purg, input int pdrop, input bit hold,
                      input int ncyc, input bit do_rst, input bit r17);
    if (do_rst) hard_reset();
    pend = r0; s_ufix = uf; s_wlen = wlen; s_gap = 20; s_preq = preq; s_purg = purg;
    s_pdrop = pdrop; s_hold = hold; rst17 = r17;
    win_left = 0; gap_left = 0; cyc = 0; n_pre = 0; n_busy = 0;
    gq.delete(); tq.delete();
    repeat (ncyc) tick();
  endtask

  initial begin
    reset = 1; island_window = 0; window_remaining = '0; req = '0; urgent = '0;
    pend = '0; s_ufix = '0; rst17 = 0;
    model_reset();
    repeat (2) @(negedge clk_pixel);
    chk_idle("por");
    reset = 0;

    // single request, one packet
    scen(4'b0001, 4'b0000, 200, 0, 0, 0, 0, 80, 1, 0);
    chk("single_npkt", gq.size(), 1);
    if (gq.size() == 1) chk("single_gnt", 32'(gq[0]), 32'h1);
    if (tq.size() == 1) chk("single_pe_cyc", tq[0], 12);
    chk("single_busy", n_busy, 44);

    // four sources back to back in one island
    scen(4'b1111, 4'b0000, 1000, 0, 0, 0, 0, 200, 1, 0);
    chk("rr_npkt", gq.size(), 4);
    if (gq.size() == 4) begin
      for (int k = 0; k < 4; k++) chk("rr_gnt", 32'(gq[k]), 32'(1) << k);
      for (int k = 0; k < 3; k++) chk("rr_spacing", tq[k+1] - tq[k], 32);
    end

    // urgent override
    scen(4'b0110, 4'b0100, 200, 0, 0, 0, 0, 120, 1, 0);
    chk("urg_npkt", gq.size(), 2);
    if (gq.size() == 2) begin
      chk("urg_first", 32'(gq[0]), 32'h4);
      chk("urg_second", 32'(gq[1]), 32'h2);
    end

    // packet cap
    scen(4'b1111, 4'b0000, 2000, 0, 0, 0, 1, 605, 1, 0);
    chk("cap_npkt", gq.size(), MAXP);

    // window boundaries
    scen(4'b1111, 4'b0000, 55, 0, 0, 0, 1, 150, 1, 0);
    chk("w55_pre", n_pre, 0);
    scen(4'b1111, 4'b0000, 56, 0, 0, 0, 1, 70, 1, 0);
    chk("w56_npkt", gq.size(), 1);
    scen(4'b1111, 4'b0000, 88, 0, 0, 0, 1, 100, 1, 0);
    chk("w88_npkt", gq.size(), 1);
    scen(4'b1111, 4'b0000, 89, 0, 0, 0, 1, 100, 1, 0);
    chk("w89_npkt", gq.size(), 2);

    // reset in the middle of a packet
    scen(4'b1111, 4'b0000, 1000, 0, 0, 0, 1, 150, 1, 1);
    chk("mid_rst_taken", 32'(rst17), 0);
    if (gq.size() >= 2) begin
      chk("mid_rst_pre_gnt", 32'(gq[0]), 32'h1);
      chk("mid_rst_post_gnt", 32'(gq[1]), 32'h1);
    end else chk("mid_rst_npkt", gq.size(), 2);

    // random traffic
    scen(4'b0000, 4'b0000, 0, 8, 15, 1, 0, 4000, 1, 0);
    scen(4'b1010, 4'b0000, 0, 20, 30, 0, 0, 4000, 0, 0);
    scen(4'b0000, 4'b0000, 0, 5, 10, 2, 1, 3000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
